// File: rtl/ps2_keyboard_if.sv
// PS/2 keyboard bundle: raw connector lines in, decoded key state out.
// master is the decoder side, slave is the keyboard/consumer side.
interface ps2_keyboard_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       press;
  logic       extended;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output keycode,
    output press,
    output extended,
    output code_valid,
    output parity_err,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  keycode,
    input  press,
    input  extended,
    input  code_valid,
    input  parity_err,
    input  frame_err
  );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 Set 2 receiver: sync + glitch filter, frame FSM,
// E0/F0 prefix decoder holding the last key and its state.
module ps2_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          Clk,
  input  logic          Reset,
  ps2_keyboard_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] TMO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  logic                  r_clk_s1;
  logic                  r_clk_s2;
  logic                  r_dat_s1;
  logic                  r_dat_s2;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_fclk;
  logic                  r_fall;
  logic                  w_all0;
  logic                  w_all1;

  assign w_all0 = (r_filt == '0);
  assign w_all1 = (r_filt == '1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= '1;
      r_fclk   <= 1'b1;
      r_fall   <= 1'b0;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_filt   <= {r_filt[FILTER_LEN-2:0], r_clk_s2};
      if (w_all0)
        r_fclk <= 1'b0;
      else if (w_all1)
        r_fclk <= 1'b1;
      r_fall   <= r_fclk & w_all0;
    end
  end

  state_t      r_state;
  state_t      w_state_n;
  logic [2:0]  r_bitcnt;
  logic [2:0]  w_bitcnt_n;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_n;
  logic        r_par;
  logic        w_par_n;
  logic [15:0] r_tmo;
  logic [15:0] w_tmo_n;
  logic        r_byte_rdy;
  logic        w_rdy_n;
  logic        r_perr;
  logic        w_perr_n;
  logic        r_ferr;
  logic        w_ferr_n;
  logic [7:0]  r_byte;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tmo      <= '0;
      r_byte_rdy <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_byte     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_bitcnt   <= w_bitcnt_n;
      r_shift    <= w_shift_n;
      r_par      <= w_par_n;
      r_tmo      <= w_tmo_n;
      r_byte_rdy <= w_rdy_n;
      r_perr     <= w_perr_n;
      r_ferr     <= w_ferr_n;
      if (w_rdy_n)
        r_byte <= r_shift;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_par_n    = r_par;
    w_tmo_n    = r_tmo;
    w_rdy_n    = 1'b0;
    w_perr_n   = 1'b0;
    w_ferr_n   = 1'b0;

    if (r_state == S_IDLE || r_fall) begin
      w_tmo_n = '0;
    end else if (r_tmo == TMO_LAST) begin
      w_tmo_n   = '0;
      w_state_n = S_IDLE;
      w_ferr_n  = 1'b1;
    end else begin
      w_tmo_n = r_tmo + 16'd1;
    end

    if (r_fall) begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) begin
            w_state_n  = S_DATA;
            w_bitcnt_n = '0;
          end
        end
        S_DATA: begin
          w_shift_n  = {r_dat_s2, r_shift[7:1]};
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7)
            w_state_n = S_PARITY;
        end
        S_PARITY: begin
          w_par_n   = r_dat_s2;
          w_state_n = S_STOP;
        end
        S_STOP: begin
          w_state_n = S_IDLE;
          // a bad stop bit masks any parity problem
          if (!r_dat_s2)
            w_ferr_n = 1'b1;
          else if (^{r_shift, r_par})
            w_rdy_n = 1'b1;
          else
            w_perr_n = 1'b1;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  logic       r_ext_pend;
  logic       r_brk_pend;
  logic [7:0] r_keycode;
  logic       r_press;
  logic       r_extended;
  logic       r_code_valid;
  logic       w_is_e0;
  logic       w_is_f0;
  logic       w_make;
  logic       w_brk;
  logic       w_match;

  assign w_is_e0 = (r_byte == 8'hE0);
  assign w_is_f0 = (r_byte == 8'hF0);
  assign w_make  = ~w_is_e0 & ~w_is_f0 & ~r_brk_pend;
  assign w_brk   = ~w_is_e0 & ~w_is_f0 & r_brk_pend;
  assign w_match = (r_byte == r_keycode) &&
                   (r_ext_pend == r_extended);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_keycode    <= '0;
      r_press      <= 1'b0;
      r_extended   <= 1'b0;
      r_code_valid <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      if (r_byte_rdy) begin
        unique case (1'b1)
          w_is_e0: r_ext_pend <= 1'b1;
          w_is_f0: r_brk_pend <= 1'b1;
          w_make: begin
            r_keycode    <= r_byte;
            r_extended   <= r_ext_pend;
            r_press      <= 1'b1;
            r_code_valid <= 1'b1;
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
          end
          w_brk: begin
            if (w_match) begin
              r_press      <= 1'b0;
              r_code_valid <= 1'b1;
            end
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.keycode    = r_keycode;
  assign bus.press      = r_press;
  assign bus.extended   = r_extended;
  assign bus.code_valid = r_code_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;

endmodule
